// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory-macro arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;
    localparam int DEPTH  = 128;

    typedef enum logic [1:0] {
        RD  = 2'd0,
        WR  = 2'd1,
        ERR = 2'd2
    } rsp_kind_e;

    // Response type of a granted request; out-of-range wins over direction.
    function automatic rsp_kind_e kind_of(input logic we, input logic in_rng);
        if (!in_rng) return ERR;
        return we ? WR : RD;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// 2-way one-hot grant. Round-robin pointer when MEM_ARB_RR_EN is defined,
// otherwise fixed priority to requester 0.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
    // ptr_q names the requester that wins a contested cycle.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_q);
        gnt_o[1] = valid_i[1] & (~valid_i[0] |  ptr_q);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0])      ptr_d = 1'b1;
        else if (gnt_o[1]) ptr_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    always_comb begin
        gnt_o[0] = valid_i[0];
        gnt_o[1] = valid_i[1] & ~valid_i[0];
    end
`endif

endmodule

// File: rtl/mem_ext_arb.sv
// Two requesters sharing one 1R1W memory macro; one grant per cycle, response
// one cycle later. Optional MEM_ARB_RR_EN selects round-robin arbitration.
// The macro's W0_clk/R0_clk are tied to clock where the macro is instantiated.
module mem_ext_arb #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int MASK_W = mem_arb_pkg::MASK_W,
    parameter int DEPTH  = mem_arb_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] mem_W0_addr,
    output logic              mem_W0_en,
    output logic [DATA_W-1:0] mem_W0_data,
    output logic [MASK_W-1:0] mem_W0_mask,
    output logic [ADDR_W-1:0] mem_R0_addr,
    output logic              mem_R0_en,
    input  logic [DATA_W-1:0] mem_R0_data
);
    import mem_arb_pkg::*;

    logic [1:0]        vld, gnt;
    logic              any_gnt, sel, in_rng;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;

    // No grants while reset is high, so nothing reaches the macro or the pipe.
    assign vld = {req1_valid, req0_valid} & {2{~reset}};

    mem_arb_pick u_pick (
        .clk_i   (clock),
        .rst_i   (reset),
        .valid_i (vld),
        .gnt_o   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign any_gnt    = |gnt;
    assign sel        = gnt[1];

    assign sel_we   = sel ? req1_we   : req0_we;
    assign sel_addr = sel ? req1_addr : req0_addr;
    assign in_rng   = sel_addr < ADDR_W'(DEPTH);

    assign mem_W0_addr = sel_addr;
    assign mem_W0_data = sel ? req1_wdata : req0_wdata;
    assign mem_W0_mask = sel ? req1_wmask : req0_wmask;
    assign mem_R0_addr = sel_addr;
    assign mem_W0_en   = any_gnt &  sel_we & in_rng;
    assign mem_R0_en   = any_gnt & ~sel_we & in_rng;

    // One-entry response pipe: who owns next cycle's response and what kind.
    logic      rsp_pend_q, rsp_pend_d;
    logic      rsp_owner_q, rsp_owner_d;
    rsp_kind_e rsp_kind_q, rsp_kind_d;

    always_comb begin
        rsp_pend_d  = any_gnt;
        rsp_owner_d = sel;
        rsp_kind_d  = any_gnt ? kind_of(sel_we, in_rng) : RD;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_kind_q  <= RD;
        end else begin
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_kind_q  <= rsp_kind_d;
        end
    end

    // Read data comes straight from the macro in the response cycle.
    logic rd_rsp;
    assign rd_rsp = rsp_kind_q == RD;

    assign rsp0_valid = rsp_pend_q & ~rsp_owner_q;
    assign rsp1_valid = rsp_pend_q &  rsp_owner_q;
    assign rsp0_err   = rsp0_valid & (rsp_kind_q == ERR);
    assign rsp1_err   = rsp1_valid & (rsp_kind_q == ERR);
    assign rsp0_data  = (rsp0_valid & rd_rsp) ? mem_R0_data : '0;
    assign rsp1_data  = (rsp1_valid & rd_rsp) ? mem_R0_data : '0;

endmodule

// File: doc/mem_ext_arb.md
MEM_EXT_ARB -- requirements
Module: mem_ext_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_W, 25, word-address width; DATA_W, 64, data width; MASK_W, 8, byte-mask width (DATA_W/8); DEPTH, 128, implemented words.
REQ-002 Ports (name, direction, width, meaning) SHALL be: clock in 1 sole clock; reset in 1 asynchronous active-high reset.
REQ-003 Per requester i in {0,1}: req<i>_valid in 1; req<i>_ready out 1; req<i>_we in 1; req<i>_addr in ADDR_W; req<i>_wdata in DATA_W; req<i>_wmask in MASK_W.
REQ-004 Per requester i: rsp<i>_valid out 1; rsp<i>_data out DATA_W; rsp<i>_err out 1 (out-of-range access).
REQ-005 Macro side: mem_W0_addr out ADDR_W; mem_W0_en out 1; mem_W0_data out DATA_W; mem_W0_mask out MASK_W; mem_R0_addr out ADDR_W; mem_R0_en out 1; mem_R0_data in DATA_W; the macro's W0_clk and R0_clk are driven from clock at top level.

Function
REQ-006 Request accepted when req<i>_valid && req<i>_ready at a rising edge; at most one grant per cycle; req<i>_ready is combinational and asserted only for the granted requester.
REQ-007 Arbitration: if only one requester is valid it is granted; if both are valid, the winner follows the policy in REQ-016.
REQ-008 Granted read (we=0, addr<DEPTH): mem_R0_en=1 and mem_R0_addr=addr in the grant cycle; in cycle N+1, rsp<i>_valid=1, rsp<i>_data=mem_R0_data, rsp<i>_err=0.
REQ-009 Granted write (we=1, addr<DEPTH): mem_W0_en=1, with addr/data/mask passed through in the grant cycle; in cycle N+1, rsp<i>_valid=1 (write ack), rsp<i>_data=0, rsp<i>_err=0.
REQ-010 Out-of-range request (addr>=DEPTH): no macro enable asserted; in cycle N+1, rsp<i>_valid=1, rsp<i>_err=1, rsp<i>_data=0.
REQ-011 Responses are single-cycle pulses with no backpressure; requesters SHALL sink them.
REQ-012 Back-to-back grants are allowed every cycle, including alternating read/write; a read granted one cycle after a write to the same address returns the new data.
REQ-013 Response owner and type are held in a one-entry pipeline register (rsp_pend, rsp_owner, rsp_kind ∈ {RD, WR, ERR}), loaded on each grant and cleared when there is no grant.
REQ-014 Macro enables are 0 whenever there is no grant; mem_W0_en and mem_R0_en are never asserted in the same cycle.

Reset
REQ-015 While reset is high: rsp*_valid=0, rsp*_err=0, rsp*_data=0, mem_*_en=0, rsp_pend=0, and the priority pointer selects requester 0; a grant cycle interrupted by reset produces no response after reset deasserts.

Configuration
REQ-016 With macro MEM_ARB_RR_EN defined: round-robin arbitration, where the priority pointer moves to the non-granted requester after every contested or uncontested grant. Without it: fixed priority with requester 0 always winning, and no pointer register.

Structure
REQ-017 A shared package mem_arb_pkg SHALL hold the rsp_kind enum (RD, WR, ERR), the default widths, and DEPTH.
REQ-018 One sub-module, mem_arb_pick (2-way grant logic with an optional pointer), is natural; everything else lives in mem_ext_arb.

Verification
REQ-019 Reset then req0 write addr=0x05, wdata=0x1122334455667788, mask=0xFF -> mem_W0_en=1 in the same cycle, rsp0_valid=1 with err=0 in the next cycle; a following read of 0x05 returns 0x1122334455667788.
REQ-020 req0 and req1 both reading continuously (addresses 0x10 and 0x20) with MEM_ARB_RR_EN -> grants alternate 0,1,0,1; without the macro -> req0 is granted every cycle and rsp1_valid never asserts.
REQ-021 req1 write addr=0x07, mask=0x0F, data=0xAAAAAAAA_BBBBBBBB over an existing word 0xFFFFFFFF_FFFFFFFF -> read back 0xFFFFFFFF_BBBBBBBB.
REQ-022 req0 read addr=0x80 (=DEPTH) -> mem_R0_en stays 0, next cycle rsp0_valid=1, rsp0_err=1, rsp0_data=0.
REQ-023 Assert reset in the cycle req1's read is granted -> after release, rsp1_valid stays 0, and the next contested grant goes to requester 0.
